// File: rtl/aud_pkg.sv
// Shared audio definitions: controller states, default widths and I2S framing constants.
// Used by the recorder today and intended for the player path as well.
package aud_pkg;

    localparam int AUD_ADDR_W   = 20;
    localparam int AUD_DATA_W   = 16;
    // BCLK cycles between the LRC edge and the MSB of the word (I2S framing)
    localparam int I2S_SKIP_CYC = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_LRC = 3'd1,
        ST_SKIP     = 3'd2,
        ST_SHIFT    = 3'd3,
        ST_WRITE    = 3'd4,
        ST_PAUSED   = 3'd5
    } aud_state_e;

    // Counter width able to hold both the skip delay and the bit count of one word
    function automatic int rx_cnt_width(input int data_w, input int skip_cyc);
        int max_v;
        max_v = (data_w > skip_cyc) ? data_w : skip_cyc;
        return $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/i2s_word_rx.sv
// I2S receive datapath: LRC falling-edge detect, skip-delay and word shift counting.
// The recorder FSM decides when to skip or shift; this block reports when each phase ends.
module i2s_word_rx
    import aud_pkg::*;
#(
    parameter int DATA_W = AUD_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lrc_i,
    input  logic              adcdat_i,
    input  logic              skip_i,
    input  logic              shift_i,
    output logic              lrc_fall_o,
    output logic              skip_done_o,
    output logic              word_done_o,
    output logic [DATA_W-1:0] word_o
);

    localparam int CNT_W = rx_cnt_width(DATA_W, I2S_SKIP_CYC);

    logic              lrc_hist_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;

    assign lrc_fall_o  = lrc_hist_q & ~lrc_i;
    assign skip_done_o = skip_i  && (cnt_q == CNT_W'(I2S_SKIP_CYC - 1));
    assign word_done_o = shift_i && (cnt_q == CNT_W'(DATA_W - 1));
    // Includes the bit arriving this cycle, so the word is complete when word_done_o is high
    assign word_o      = shreg_d;

    // Next-state for the phase counter and the MSB-first shift register
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (skip_i) begin
            cnt_d = skip_done_o ? CNT_W'(0) : cnt_q + CNT_W'(1);
        end else if (shift_i) begin
            shreg_d = {shreg_q[DATA_W-2:0], adcdat_i};
            cnt_d   = word_done_o ? CNT_W'(0) : cnt_q + CNT_W'(1);
        end else begin
            cnt_d = CNT_W'(0);
        end
    end

    // LRC history, counter and shift register state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lrc_hist_q <= 1'b1;
            cnt_q      <= CNT_W'(0);
            shreg_q    <= {DATA_W{1'b0}};
        end else begin
            lrc_hist_q <= lrc_i;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
        end
    end

endmodule

// File: rtl/aud_recorder.sv
// Audio recorder: captures left-channel I2S samples and writes them to sequential SRAM words.
// Handles start/pause/stop commands and stops with o_full when the address space is used up.
module aud_recorder
    import aud_pkg::*;
#(
    parameter int ADDR_W = AUD_ADDR_W,
    parameter int DATA_W = AUD_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_init_done,
    input  logic              i_lrc,
    input  logic              i_adcdat,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_stop_addr,
    output logic              o_full,
    output logic              o_busy
);

    aud_state_e        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] stop_addr_q, stop_addr_d;
    logic              we_q, we_d;
    logic              full_q, full_d;
    logic              busy_q, busy_d;
    logic              pend_q, pend_d;

    logic              skip_s;
    logic              shift_s;
    logic              lrc_fall_s;
    logic              skip_done_s;
    logic              word_done_s;
    logic [DATA_W-1:0] word_s;
    logic              stop_s;

    i2s_word_rx #(
        .DATA_W (DATA_W)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .lrc_i       (i_lrc),
        .adcdat_i    (i_adcdat),
        .skip_i      (skip_s),
        .shift_i     (shift_s),
        .lrc_fall_o  (lrc_fall_s),
        .skip_done_o (skip_done_s),
        .word_done_o (word_done_s),
        .word_o      (word_s)
    );

    // Losing codec configuration mid-recording aborts exactly like a stop command
    assign stop_s = i_stop | ~i_init_done;
    assign busy_d = (state_d != ST_IDLE);

    // Next-state, addressing and write-strobe decisions
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        addr_d      = addr_q;
        stop_addr_d = stop_addr_q;
        we_d        = 1'b0;
        full_d      = full_q;
        pend_d      = pend_q;
        skip_s      = 1'b0;
        shift_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pend_d = 1'b0;
                if (i_start && i_init_done) begin
                    state_d = ST_WAIT_LRC;
                    addr_d  = {ADDR_W{1'b0}};
                    full_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_LRC: begin
                if (stop_s) begin
                    state_d = ST_IDLE;
                end else if (i_pause) begin
                    state_d = ST_PAUSED;
                end else if (lrc_fall_s) begin
                    state_d = ST_SKIP;
                end else begin
                    state_d = ST_WAIT_LRC;
                end
            end
            ST_SKIP: begin
                skip_s = 1'b1;
                if (stop_s) begin
                    state_d = ST_IDLE;
                end else begin
                    pend_d  = pend_q | i_pause;
                    state_d = skip_done_s ? ST_SHIFT : ST_SKIP;
                end
            end
            ST_SHIFT: begin
                shift_s = 1'b1;
                if (stop_s) begin
                    state_d = ST_IDLE;
                end else if (word_done_s) begin
                    pend_d  = pend_q | i_pause;
                    state_d = ST_WRITE;
                    we_d    = 1'b1;
                    data_d  = word_s;
                end else begin
                    pend_d  = pend_q | i_pause;
                    state_d = ST_SHIFT;
                end
            end
            ST_WRITE: begin
                // The strobe is already visible this cycle, so the word counts as written
                stop_addr_d = addr_q;
                pend_d      = 1'b0;
                if (stop_s) begin
                    state_d = ST_IDLE;
                end else if (addr_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_IDLE;
                    full_d  = 1'b1;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = (pend_q || i_pause) ? ST_PAUSED : ST_WAIT_LRC;
                end
            end
            ST_PAUSED: begin
                pend_d = 1'b0;
                if (stop_s) begin
                    state_d = ST_IDLE;
                end else if (i_start) begin
                    state_d = ST_WAIT_LRC;
                end else begin
                    state_d = ST_PAUSED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            data_q      <= {DATA_W{1'b0}};
            addr_q      <= {ADDR_W{1'b0}};
            stop_addr_q <= {ADDR_W{1'b0}};
            we_q        <= 1'b0;
            full_q      <= 1'b0;
            busy_q      <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            stop_addr_q <= stop_addr_d;
            we_q        <= we_d;
            full_q      <= full_d;
            busy_q      <= busy_d;
            pend_q      <= pend_d;
        end
    end

    assign o_data      = data_q;
    assign o_addr      = addr_q;
    assign o_stop_addr = stop_addr_q;
    assign o_we        = we_q;
    assign o_full      = full_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_aud_recorder.sv
// Bench for aud_recorder: two instances (20-bit and 3-bit address) share one I2S stream and
// command sequence; a frame-level model predicts every SRAM write and the end-of-frame status.
module tb_aud_recorder;

    localparam int C_NONE  = 0;
    localparam int C_START = 1;
    localparam int C_PAUSE = 2;
    localparam int C_STOP  = 3;
    localparam int C_DROP  = 4;

    localparam int M_IDLE   = 0;
    localparam int M_REC    = 1;
    localparam int M_PAUSED = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done, lrc, adcdat, start, pause, stop;
    logic [15:0] data_b, data_s;
    logic [19:0] addr_b, saddr_b;
    logic [2:0]  addr_s, saddr_s;
    logic        we_b, we_s, full_b, full_s, busy_b, busy_s;

    always #5 clk = ~clk;

    aud_recorder #(.ADDR_W(20), .DATA_W(16)) dut_b (
        .clk(clk), .rst(rst), .i_init_done(init_done), .i_lrc(lrc), .i_adcdat(adcdat),
        .i_start(start), .i_pause(pause), .i_stop(stop),
        .o_data(data_b), .o_addr(addr_b), .o_we(we_b), .o_stop_addr(saddr_b),
        .o_full(full_b), .o_busy(busy_b)
    );

    aud_recorder #(.ADDR_W(3), .DATA_W(16)) dut_s (
        .clk(clk), .rst(rst), .i_init_done(init_done), .i_lrc(lrc), .i_adcdat(adcdat),
        .i_start(start), .i_pause(pause), .i_stop(stop),
        .o_data(data_s), .o_addr(addr_s), .o_we(we_s), .o_stop_addr(saddr_s),
        .o_full(full_s), .o_busy(busy_s)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    typedef struct {
        int          addr;
        logic [15:0] data;
    } wr_t;

    wr_t q_b[$];
    wr_t q_s[$];

    int m_mode[2];
    int m_addr[2];
    int m_stop[2];
    int m_full[2];
    int m_max[2];

    // Frame-level reference: one command per frame, either inside the capture window or after it
    task automatic model_frame(input int k, input logic [15:0] left, input int cmd, input bit mid);
        wr_t w;
        bit  kill;
        kill = (cmd == C_STOP) || (cmd == C_DROP);
        if (m_mode[k] == M_REC) begin
            if (kill && mid) begin
                m_mode[k] = M_IDLE;
            end else begin
                w.addr = m_addr[k];
                w.data = left;
                if (k == 0) q_b.push_back(w); else q_s.push_back(w);
                m_stop[k] = m_addr[k];
                if (m_addr[k] == m_max[k]) begin
                    m_full[k] = 1;
                    m_mode[k] = M_IDLE;
                end else begin
                    m_addr[k] = m_addr[k] + 1;
                    if (kill) m_mode[k] = M_IDLE;
                    else if (cmd == C_PAUSE) m_mode[k] = M_PAUSED;
                end
            end
        end else if (m_mode[k] == M_PAUSED) begin
            if (kill) m_mode[k] = M_IDLE;
            else if (cmd == C_START) m_mode[k] = M_REC;
        end else begin
            if (cmd == C_START) begin
                m_mode[k] = M_REC;
                m_addr[k] = 0;
                m_full[k] = 0;
            end
        end
    endtask

    // One 64-BCLK frame: left half LRC low, word MSB at cycle 2; right word in the high half
    task automatic run_frame(input logic [15:0] left, input logic [15:0] right,
                             input int cmd, input int cpos, input bit whole);
        if (whole) begin
            model_frame(0, left, cmd, cpos < 20);
            model_frame(1, left, cmd, cpos < 20);
        end
        for (int c = 0; c < (whole ? 64 : 18); c++) begin
            lrc = (c >= 32);
            if (c >= 2 && c <= 17)       adcdat = left[17 - c];
            else if (c >= 34 && c <= 49) adcdat = right[49 - c];
            else                         adcdat = 1'($urandom);
            start     = (c == cpos) && (cmd == C_START || cmd == C_DROP);
            pause     = (c == cpos) && (cmd == C_PAUSE);
            stop      = (c == cpos) && (cmd == C_STOP);
            init_done = !((c == cpos) && (cmd == C_DROP));
            @(posedge clk);
            #1;
            if (c == cpos && (cmd == C_STOP || cmd == C_DROP)) begin
                check("busy_after_stop_b", 32'(busy_b), 32'd0);
                check("busy_after_stop_s", 32'(busy_s), 32'd0);
            end
        end
        start     = 1'b0;
        pause     = 1'b0;
        stop      = 1'b0;
        init_done = 1'b1;
        if (whole) begin
            check("wr_missing_b", 32'(q_b.size()), 32'd0);
            check("wr_missing_s", 32'(q_s.size()), 32'd0);
            check("busy_b", 32'(busy_b), 32'(m_mode[0] != M_IDLE));
            check("busy_s", 32'(busy_s), 32'(m_mode[1] != M_IDLE));
            check("full_b", 32'(full_b), 32'(m_full[0]));
            check("full_s", 32'(full_s), 32'(m_full[1]));
            check("stop_addr_b", 32'(saddr_b), 32'(m_stop[0]));
            check("stop_addr_s", 32'(saddr_s), 32'(m_stop[1]));
        end
        q_b.delete();
        q_s.delete();
    endtask

    // Write monitors: every strobe must match the oldest predicted write
    always @(negedge clk) begin
        wr_t wb;
        if (we_b) begin
            if (q_b.size() == 0) begin
                check("unexpected_we_b", 32'(we_b), 32'd0);
            end else begin
                wb = q_b.pop_front();
                check("wr_addr_b", 32'(addr_b), 32'(wb.addr));
                check("wr_data_b", 32'(data_b), 32'(wb.data));
            end
        end
    end

    always @(negedge clk) begin
        wr_t ws;
        if (we_s) begin
            if (q_s.size() == 0) begin
                check("unexpected_we_s", 32'(we_s), 32'd0);
            end else begin
                ws = q_s.pop_front();
                check("wr_addr_s", 32'(addr_s), 32'(ws.addr));
                check("wr_data_s", 32'(data_s), 32'(ws.data));
            end
        end
    end

    task automatic check_reset_outputs(input string phase);
        check({phase, "_data_b"},  32'(data_b),  32'd0);
        check({phase, "_addr_b"},  32'(addr_b),  32'd0);
        check({phase, "_we_b"},    32'(we_b),    32'd0);
        check({phase, "_stop_b"},  32'(saddr_b), 32'd0);
        check({phase, "_full_b"},  32'(full_b),  32'd0);
        check({phase, "_busy_b"},  32'(busy_b),  32'd0);
        check({phase, "_we_s"},    32'(we_s),    32'd0);
        check({phase, "_busy_s"},  32'(busy_s),  32'd0);
    endtask

    initial begin
        int cmd;
        int cpos;
        int r;
        rst       = 1'b0;
        init_done = 1'b1;
        lrc       = 1'b1;
        adcdat    = 1'b0;
        start     = 1'b0;
        pause     = 1'b0;
        stop      = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = M_IDLE;
            m_addr[k] = 0;
            m_stop[k] = 0;
            m_full[k] = 0;
        end
        m_max[0] = (1 << 20) - 1;
        m_max[1] = 7;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single word capture; right word must never be written
        run_frame(16'($urandom), 16'($urandom), C_START, 40, 1'b1);
        run_frame(16'hA5C3, 16'hFFFF, C_NONE, -1, 1'b1);
        // Restart and three consecutive frames from address 0
        run_frame(16'($urandom), 16'($urandom), C_STOP, 30, 1'b1);
        run_frame(16'($urandom), 16'($urandom), C_START, 50, 1'b1);
        run_frame(16'h0001, 16'($urandom), C_NONE, -1, 1'b1);
        run_frame(16'h8000, 16'($urandom), C_NONE, -1, 1'b1);
        run_frame(16'h7FFF, 16'($urandom), C_NONE, -1, 1'b1);
        // Pause at bit 8, four idle frames, resume
        run_frame(16'($urandom), 16'($urandom), C_PAUSE, 10, 1'b1);
        repeat (4) run_frame(16'($urandom), 16'($urandom), C_NONE, -1, 1'b1);
        run_frame(16'($urandom), 16'($urandom), C_START, 33, 1'b1);
        run_frame(16'($urandom), 16'($urandom), C_NONE, -1, 1'b1);
        // Stop at bit 5 discards the word
        run_frame(16'($urandom), 16'($urandom), C_STOP, 7, 1'b1);
        // Start without codec init is ignored
        run_frame(16'($urandom), 16'($urandom), C_DROP, 25, 1'b1);
        run_frame(16'($urandom), 16'($urandom), C_NONE, -1, 1'b1);
        // Fill the 3-bit instance: 8 writes, then the 9th frame is ignored
        run_frame(16'($urandom), 16'($urandom), C_START, 45, 1'b1);
        repeat (9) run_frame(16'($urandom), 16'($urandom), C_NONE, -1, 1'b1);

        repeat (150) begin
            r = $urandom_range(0, 9);
            cmd = (r < 4) ? C_NONE : (r < 6) ? C_START : (r < 7) ? C_STOP :
                  (r < 8) ? C_DROP : C_PAUSE;
            if (cmd == C_NONE)           cpos = -1;
            else if ($urandom_range(0, 1) == 0)
                cpos = (cmd == C_PAUSE || cmd == C_START) ? 10 : 7;
            else                         cpos = $urandom_range(20, 63);
            run_frame(16'($urandom), 16'($urandom), cmd, cpos, 1'b1);
        end

        // Reset asserted while the write strobe is high must clear it without a clock edge
        run_frame(16'($urandom), 16'($urandom), C_STOP, 30, 1'b1);
        run_frame(16'($urandom), 16'($urandom), C_START, 30, 1'b1);
        run_frame(16'h1234, 16'($urandom), C_NONE, -1, 1'b0);
        check("we_before_rst_b", 32'(we_b), 32'd1);
        check("we_before_rst_s", 32'(we_s), 32'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/aud_recorder.md
AUD_RECORDER -- requirements
Module: aud_recorder

Interface
REQ-001 Parameter ADDR_W, default 20, SRAM word-address width.
REQ-002 Parameter DATA_W, default 16, audio sample width; matches codec 16-bit I2S word length.
REQ-003 clk  in  1  codec bit clock AUD_BCLK; all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 i_init_done  in  1  codec configuration complete (level, from I2C init block).
REQ-006 i_lrc  in  1  codec ADCLRCK; low = left channel.
REQ-007 i_adcdat  in  1  codec ADCDAT serial data, MSB first.
REQ-008 i_start / i_pause / i_stop  in  1 each  single-cycle command pulses.
REQ-009 o_data  out  DATA_W  captured left-channel sample.
REQ-010 o_addr  out  ADDR_W  SRAM write address for o_data.
REQ-011 o_we  out  1  one-cycle write strobe; o_data/o_addr valid while high.
REQ-012 o_stop_addr  out  ADDR_W  address of last written sample (recording length).
REQ-013 o_full  out  1  memory exhausted, recording ended.
REQ-014 o_busy  out  1  high in any state except IDLE.

Function
REQ-015 States: IDLE, WAIT_LRC, SKIP, SHIFT, WRITE, PAUSED.
REQ-016 IDLE: i_start with i_init_done=1 -> WAIT_LRC, o_addr<=0, o_full<=0; i_start with i_init_done=0 ignored.
REQ-017 WAIT_LRC: on i_lrc 1->0 transition (previous-cycle i_lrc registered) -> SKIP.
REQ-018 SKIP: one cycle (I2S one-BCLK delay) -> SHIFT, bit counter cleared.
REQ-019 SHIFT: shift i_adcdat into shift register LSB each cycle for exactly DATA_W cycles, then -> WRITE.
REQ-020 WRITE: o_we=1 for exactly one cycle, o_data=shift register, o_addr=current address; o_stop_addr<=o_addr.
REQ-021 After WRITE: if o_addr=2^ADDR_W-1 -> IDLE, o_full<=1; else o_addr<=o_addr+1 and -> PAUSED if pause pending, else WAIT_LRC.
REQ-022 i_pause in WAIT_LRC -> PAUSED immediately; in SKIP/SHIFT/WRITE sets pause-pending flag, current word completes and is written.
REQ-023 PAUSED: i_start -> WAIT_LRC, address preserved; o_we held 0.
REQ-024 i_stop in any non-IDLE state -> IDLE next cycle; partial word discarded, no write; o_stop_addr keeps last written address.
REQ-025 i_stop and i_start/i_pause same cycle: i_stop wins; i_start while busy (not PAUSED) ignored.
REQ-026 i_init_done falling while busy treated as i_stop.
REQ-027 Right-channel bits (i_lrc high) never captured.

Reset
REQ-028 rst low: state IDLE, o_data=0, o_addr=0, o_we=0, o_stop_addr=0, o_full=0, o_busy=0, shift register, bit counter, pause flag, lrc history cleared (history=1).
REQ-029 rst asserted mid-SHIFT or mid-WRITE: o_we drops asynchronously, no write completes.

Structure
REQ-030 Shared package aud_pkg holds state enum, DATA_W/ADDR_W defaults, I2S skip-delay constant; reused by future aud_player.
REQ-031 One sub-module natural: i2s_word_rx (lrc edge detect, skip, DATA_W-bit shift, word-ready pulse); FSM and addressing in aud_recorder.

Verification
REQ-032 Start, LRC falls, left word 16'hA5C3 serialized MSB-first after 1-BCLK delay -> single o_we at o_addr=0, o_data=16'hA5C3; right word 16'hFFFF never written.
REQ-033 Three consecutive frames 16'h0001/16'h8000/16'h7FFF -> writes at addresses 0,1,2 with those values; o_stop_addr=2.
REQ-034 i_pause at bit 8 of frame 2 -> frame 2 written at address 1, no write during next 4 frames, i_start -> next word at address 2.
REQ-035 i_stop at bit 5 -> no o_we, IDLE next cycle, o_busy=0, o_stop_addr unchanged.
REQ-036 ADDR_W=3, 8 frames -> last write at address 7, then o_full=1, IDLE; 9th frame ignored.
REQ-037 i_start with i_init_done=0 -> stays IDLE; rst low mid-SHIFT -> all outputs reset values immediately.
